// File: rtl/ex_branch_rs_pkg.sv
// Shared definitions for the in-order branch reservation queue:
// opcode encodings, the unlocked-tag constant and default widths.
package ex_branch_rs_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int TAG_W_DEF = 4;
   localparam int UNLOCKED  = 0;

   // Encodings follow the RISC-V funct3 field; 3'b010 and 3'b011 are illegal.
   typedef enum logic [2:0] {
      BR_BEQ  = 3'b000,
      BR_BNE  = 3'b001,
      BR_BLT  = 3'b100,
      BR_BGE  = 3'b101,
      BR_BLTU = 3'b110,
      BR_BGEU = 3'b111
   } br_op_e;

   // Entry record at the default widths. The queue builds the same layout
   // from its own XLEN/TAG_W parameters, with valid held in a reset vector.
   typedef struct packed {
      br_op_e                op;
      logic [XLEN_DEF-1:0]   pc;
      logic [XLEN_DEF-1:0]   offset;
      logic                  pred;
      logic [TAG_W_DEF-1:0]  tagx;
      logic [TAG_W_DEF-1:0]  tagy;
      logic [XLEN_DEF-1:0]   datax;
      logic [XLEN_DEF-1:0]   datay;
      logic                  valid;
   } br_entry_t;

endpackage

// File: rtl/ex_branch_rs_if.sv
// Issue, result-bus and resolve signals of the branch reservation queue.
// master = allocator/CDB/IF side, slave = the queue.
interface ex_branch_rs_if
   import ex_branch_rs_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int TAG_W = TAG_W_DEF
);
   logic             rdy;
   logic             flush_in;
   logic             issue_valid;
   logic             issue_ready;
   logic [2:0]       issue_op;
   logic [XLEN-1:0]  issue_pc;
   logic [XLEN-1:0]  issue_offset;
   logic             issue_pred_taken;
   logic [TAG_W-1:0] issue_tagx;
   logic [TAG_W-1:0] issue_tagy;
   logic [XLEN-1:0]  issue_datax;
   logic [XLEN-1:0]  issue_datay;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [XLEN-1:0]  cdb_data;
   logic             res_valid;
   logic             res_taken;
   logic             res_mispredict;
   logic [XLEN-1:0]  res_dest;
   logic             busy_out;

   modport master (
      output rdy, flush_in, issue_valid, issue_op, issue_pc, issue_offset,
             issue_pred_taken, issue_tagx, issue_tagy, issue_datax, issue_datay,
             cdb_valid, cdb_tag, cdb_data,
      input  issue_ready, res_valid, res_taken, res_mispredict, res_dest, busy_out
   );

   modport slave (
      input  rdy, flush_in, issue_valid, issue_op, issue_pc, issue_offset,
             issue_pred_taken, issue_tagx, issue_tagy, issue_datax, issue_datay,
             cdb_valid, cdb_tag, cdb_data,
      output issue_ready, res_valid, res_taken, res_mispredict, res_dest, busy_out
   );
endinterface

// File: rtl/ex_branch_rs_br_compare.sv
// Combinational branch condition evaluator: (op, x, y) -> taken/legal.
// Kept standalone so JALR and fused-compare paths can reuse it.
module br_compare
   import ex_branch_rs_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  br_op_e          op,
   input  logic [XLEN-1:0] x,
   input  logic [XLEN-1:0] y,
   output logic            taken,
   output logic            legal
);

   always_comb begin
      taken = 1'b0;
      legal = 1'b1;
      case (op)
         BR_BEQ:  taken = (x == y);
         BR_BNE:  taken = (x != y);
         BR_BLT:  taken = ($signed(x) <  $signed(y));
         BR_BGE:  taken = ($signed(x) >= $signed(y));
         BR_BLTU: taken = (x <  y);
         BR_BGEU: taken = (x >= y);
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/ex_branch_rs.sv
// DEPTH-entry in-order branch reservation queue with CDB operand wakeup.
// Resolves the head only, redirects IF on mispredict and flushes younger entries.
module ex_branch_rs
   import ex_branch_rs_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = XLEN_DEF,
   parameter int TAG_W = TAG_W_DEF
) (
   input logic           clk,
   input logic           rst_n,
   ex_branch_rs_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      br_op_e           op;
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  offset;
      logic             pred;
      logic [TAG_W-1:0] tagx;
      logic [TAG_W-1:0] tagy;
      logic [XLEN-1:0]  datax;
      logic [XLEN-1:0]  datay;
   } entry_t;

   entry_t            ent_q [DEPTH];
   logic [DEPTH-1:0]  valid_q;
   logic [PTR_W-1:0]  head_q;
   logic [PTR_W-1:0]  tail_q;
   logic [CNT_W-1:0]  count_q;

   logic              res_valid_q;
   logic              res_taken_q;
   logic              res_mispredict_q;
   logic [XLEN-1:0]   res_dest_q;

   entry_t            head_e;
   entry_t            new_e;
   logic              issue_ready;
   logic              issue_fire;
   logic              head_ready;
   logic              resolve;
   logic              cmp_taken;
   logic              cmp_legal;
   logic              mispredict_now;
   logic              clear;
   logic [XLEN-1:0]   target;
   logic [XLEN-1:0]   fall_thru;

   function automatic logic cdb_hit(input logic [TAG_W-1:0] tag,
                                    input logic             cdb_v,
                                    input logic [TAG_W-1:0] cdb_t);
      return cdb_v && (tag != TAG_W'(UNLOCKED)) && (tag == cdb_t);
   endfunction

   assign head_e      = ent_q[head_q];
   assign issue_ready = (count_q < CNT_W'(DEPTH)) && !bus.flush_in;
   assign issue_fire  = bus.issue_valid && issue_ready && bus.rdy;
   assign head_ready  = valid_q[head_q] &&
                        (head_e.tagx == TAG_W'(UNLOCKED)) &&
                        (head_e.tagy == TAG_W'(UNLOCKED));
   assign resolve     = bus.rdy && !bus.flush_in && head_ready;

   br_compare #(.XLEN(XLEN)) u_cmp (
      .op    (head_e.op),
      .x     (head_e.datax),
      .y     (head_e.datay),
      .taken (cmp_taken),
      .legal (cmp_legal)
   );

   assign target         = head_e.pc + head_e.offset;
   assign fall_thru      = head_e.pc + XLEN'(4);
   assign mispredict_now = resolve && cmp_legal && (cmp_taken ^ head_e.pred);
   // A mispredict kills everything younger, including a same-cycle issue.
   assign clear          = bus.flush_in || mispredict_now;

   always_comb begin
      new_e        = '0;
      new_e.op     = br_op_e'(bus.issue_op);
      new_e.pc     = bus.issue_pc;
      new_e.offset = bus.issue_offset;
      new_e.pred   = bus.issue_pred_taken;
      new_e.tagx   = bus.issue_tagx;
      new_e.tagy   = bus.issue_tagy;
      new_e.datax  = bus.issue_datax;
      new_e.datay  = bus.issue_datay;
      if (cdb_hit(bus.issue_tagx, bus.cdb_valid, bus.cdb_tag)) begin
         new_e.tagx  = TAG_W'(UNLOCKED);
         new_e.datax = bus.cdb_data;
      end
      if (cdb_hit(bus.issue_tagy, bus.cdb_valid, bus.cdb_tag)) begin
         new_e.tagy  = TAG_W'(UNLOCKED);
         new_e.datay = bus.cdb_data;
      end
   end

   // Payload is never reset; valid_q alone decides whether an entry counts.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (issue_fire && (tail_q == PTR_W'(i))) begin
            ent_q[i] <= new_e;
         end else if (valid_q[i]) begin
            if (cdb_hit(ent_q[i].tagx, bus.cdb_valid, bus.cdb_tag)) begin
               ent_q[i].tagx  <= TAG_W'(UNLOCKED);
               ent_q[i].datax <= bus.cdb_data;
            end
            if (cdb_hit(ent_q[i].tagy, bus.cdb_valid, bus.cdb_tag)) begin
               ent_q[i].tagy  <= TAG_W'(UNLOCKED);
               ent_q[i].datay <= bus.cdb_data;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else if (clear) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         if (resolve) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + PTR_W'(1);
         end
         if (issue_fire) begin
            valid_q[tail_q] <= 1'b1;
            tail_q          <= tail_q + PTR_W'(1);
         end
         count_q <= count_q + CNT_W'(issue_fire) - CNT_W'(resolve);
      end
   end

   // Illegal opcodes pop silently; taken/dest hold their last legal values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid_q      <= 1'b0;
         res_taken_q      <= 1'b0;
         res_mispredict_q <= 1'b0;
         res_dest_q       <= '0;
      end else if (resolve && cmp_legal) begin
         res_valid_q      <= 1'b1;
         res_taken_q      <= cmp_taken;
         res_mispredict_q <= cmp_taken ^ head_e.pred;
         res_dest_q       <= cmp_taken ? target : fall_thru;
      end else begin
         res_valid_q      <= 1'b0;
         res_mispredict_q <= 1'b0;
      end
   end

   assign bus.issue_ready    = issue_ready;
   assign bus.res_valid      = res_valid_q;
   assign bus.res_taken      = res_taken_q;
   assign bus.res_mispredict = res_mispredict_q;
   assign bus.res_dest       = res_dest_q;
   assign bus.busy_out       = (count_q != '0);

endmodule

// File: tb/tb_ex_branch_rs.sv
// Bench for ex_branch_rs: directed scenarios plus random traffic, all
// checked every cycle against a queue-based reference model.
module tb_ex_branch_rs;
   import ex_branch_rs_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ex_branch_rs_if #(.XLEN(32), .TAG_W(4)) bus ();

   ex_branch_rs #(.DEPTH(DEPTH), .XLEN(32), .TAG_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] pc;
      logic [31:0] off;
      logic        pred;
      logic [3:0]  tx;
      logic [3:0]  ty;
      logic [31:0] dx;
      logic [31:0] dy;
   } ent_t;

   ent_t        mq[$];
   bit          m_rv, m_rt, m_rm;
   logic [31:0] m_rd;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit eval_br(input ent_t e, output bit tk);
      tk = 1'b0;
      case (e.op)
         3'b000: tk = (e.dx == e.dy);
         3'b001: tk = (e.dx != e.dy);
         3'b100: tk = ($signed(e.dx) <  $signed(e.dy));
         3'b101: tk = ($signed(e.dx) >= $signed(e.dy));
         3'b110: tk = (e.dx <  e.dy);
         3'b111: tk = (e.dx >= e.dy);
         default: return 1'b0;
      endcase
      return 1'b1;
   endfunction

   function automatic bit hit(input logic [3:0] t);
      return bus.cdb_valid && (t != 4'd0) && (t == bus.cdb_tag);
   endfunction

   task automatic snoop();
      for (int i = 0; i < mq.size(); i++) begin
         if (hit(mq[i].tx)) begin mq[i].tx = 4'd0; mq[i].dx = bus.cdb_data; end
         if (hit(mq[i].ty)) begin mq[i].ty = 4'd0; mq[i].dy = bus.cdb_data; end
      end
   endtask

   task automatic model_edge();
      bit   fire, tk, legal, kill;
      ent_t e;
      fire = bus.issue_valid && (mq.size() < DEPTH) && !bus.flush_in && bus.rdy;
      m_rv = 0;
      m_rm = 0;
      if (bus.flush_in) begin
         mq.delete();
      end else if (!bus.rdy) begin
         snoop();
      end else begin
         kill = 0;
         if (mq.size() > 0 && mq[0].tx == 4'd0 && mq[0].ty == 4'd0) begin
            e = mq.pop_front();
            legal = eval_br(e, tk);
            if (legal) begin
               m_rv = 1;
               m_rt = tk;
               m_rd = tk ? e.pc + e.off : e.pc + 32'd4;
               m_rm = tk ^ e.pred;
               kill = m_rm;
            end
         end
         if (kill) begin
            mq.delete();
         end else begin
            snoop();
            if (fire) begin
               e.op = bus.issue_op;  e.pc = bus.issue_pc;  e.off = bus.issue_offset;
               e.pred = bus.issue_pred_taken;
               e.tx = bus.issue_tagx; e.ty = bus.issue_tagy;
               e.dx = bus.issue_datax; e.dy = bus.issue_datay;
               if (hit(e.tx)) begin e.tx = 4'd0; e.dx = bus.cdb_data; end
               if (hit(e.ty)) begin e.ty = 4'd0; e.dy = bus.cdb_data; end
               mq.push_back(e);
            end
         end
      end
   endtask

   task automatic step();
      #1;
      check_val("issue_ready", bus.issue_ready, (mq.size() < DEPTH) && !bus.flush_in);
      @(posedge clk);
      model_edge();
      #1;
      check_val("res_valid", bus.res_valid, m_rv);
      check_val("res_mispredict", bus.res_mispredict, m_rm);
      check_val("res_taken", bus.res_taken, m_rt);
      check_val("res_dest", bus.res_dest, m_rd);
      check_val("busy_out", bus.busy_out, mq.size() != 0);
      @(negedge clk);
   endtask

   task automatic idle();
      bus.rdy = 1'b1; bus.flush_in = 1'b0; bus.issue_valid = 1'b0;
      bus.cdb_valid = 1'b0; bus.cdb_tag = 4'd0; bus.cdb_data = 32'd0;
   endtask

   task automatic put(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] off,
                      input logic pred, input logic [3:0] tx, input logic [3:0] ty,
                      input logic [31:0] dx, input logic [31:0] dy);
      bus.issue_valid = 1'b1; bus.issue_op = op; bus.issue_pc = pc; bus.issue_offset = off;
      bus.issue_pred_taken = pred; bus.issue_tagx = tx; bus.issue_tagy = ty;
      bus.issue_datax = dx; bus.issue_datay = dy;
   endtask

   task automatic cdb(input logic [3:0] t, input logic [31:0] d);
      bus.cdb_valid = 1'b1; bus.cdb_tag = t; bus.cdb_data = d;
   endtask

   task automatic model_reset();
      mq.delete(); m_rv = 0; m_rt = 0; m_rm = 0; m_rd = 32'd0;
   endtask

   initial begin
      logic [31:0] pool [4];
      pool[0] = 32'd0; pool[1] = 32'd1; pool[2] = 32'hFFFF_FFFF; pool[3] = 32'h8000_0000;
      idle();
      put(3'b000, 0, 0, 0, 0, 0, 0, 0);
      bus.issue_valid = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_val("rst_res_valid", bus.res_valid, 0);
      check_val("rst_res_dest", bus.res_dest, 0);
      check_val("rst_busy", bus.busy_out, 0);
      check_val("rst_issue_ready", bus.issue_ready, 1);
      rst_n = 1'b1;
      @(negedge clk);

      // ready operands
      put(BR_BEQ, 32'h100, 32'h20, 1, 0, 0, 5, 5); step();
      idle(); step();
      check_val("beq_valid", bus.res_valid, 1);
      check_val("beq_taken", bus.res_taken, 1);
      check_val("beq_misp", bus.res_mispredict, 0);
      check_val("beq_dest", bus.res_dest, 32'h120);
      check_val("beq_busy", bus.busy_out, 0);

      // CDB wakeup of a signed compare
      put(BR_BLT, 32'h200, 32'h40, 0, 3, 0, 0, 7); step();
      idle(); step(); step();
      cdb(3, 32'hFFFF_FFFF); step();
      idle(); step();
      check_val("blt_valid", bus.res_valid, 1);
      check_val("blt_taken", bus.res_taken, 1);
      check_val("blt_misp", bus.res_mispredict, 1);
      check_val("blt_dest", bus.res_dest, 32'h240);

      // head blocks ready younger entries; full queue refuses issue
      put(BR_BEQ,  32'h300, 8, 1, 2, 0, 0, 9); step();
      put(BR_BNE,  32'h310, 8, 0, 0, 0, 1, 1); step();
      put(BR_BGE,  32'h320, 8, 1, 0, 0, 5, 3); step();
      put(BR_BGEU, 32'h330, 8, 0, 0, 0, 1, 2); step();
      put(BR_BEQ,  32'h340, 8, 1, 0, 0, 1, 1); step(); step();
      check_val("full_ready", bus.issue_ready, 0);
      idle(); step();
      cdb(2, 9); step();
      idle(); step();
      check_val("ord0_dest", bus.res_dest, 32'h308);
      step();
      check_val("ord1_dest", bus.res_dest, 32'h314);
      step(); step(); step();

      // mispredict flush discards younger and same-cycle issue
      put(BR_BLTU, 32'h400, 32'h10, 0, 4, 0, 0, 2); step();
      put(BR_BEQ,  32'h410, 4, 1, 5, 0, 0, 0); step();
      put(BR_BEQ,  32'h420, 4, 1, 5, 0, 0, 0); step();
      idle(); cdb(4, 1); step();
      idle(); put(BR_BEQ, 32'h500, 4, 1, 0, 0, 0, 0); step();
      check_val("mf_misp", bus.res_mispredict, 1);
      check_val("mf_dest", bus.res_dest, 32'h410);
      check_val("mf_busy", bus.busy_out, 0);
      idle(); step();

      // address wrap
      put(BR_BNE, 32'hFFFF_FFFC, 32'h10, 1, 0, 0, 3, 3); step();
      idle(); step();
      check_val("wrap_dest", bus.res_dest, 32'h0);
      check_val("wrap_taken", bus.res_taken, 0);
      for (int i = 0; i < 10; i++) begin
         put(BR_BGEU, 32'h1000 + 32'(i * 16), 32'h80, (i >= 5), 0, 0, 32'(i), 5);
         step();
      end
      idle(); step(); step();

      // rdy freeze with CDB capture
      put(BR_BEQ, 32'h600, 8, 1, 6, 0, 0, 3); step();
      put(BR_BNE, 32'h610, 8, 1, 0, 5, 1, 0); step();
      idle(); bus.rdy = 1'b0; cdb(6, 3); step();
      idle(); bus.rdy = 1'b0; cdb(5, 2); step();
      idle(); bus.rdy = 1'b0; step();
      check_val("frz_valid", bus.res_valid, 0);
      check_val("frz_busy", bus.busy_out, 1);
      idle(); step();
      check_val("frz_dest", bus.res_dest, 32'h608);
      step(); step();

      // external flush with a ready head
      put(BR_BEQ, 32'h700, 8, 1, 0, 0, 1, 1); step();
      idle(); bus.flush_in = 1'b1; step();
      check_val("fl_valid", bus.res_valid, 0);
      check_val("fl_busy", bus.busy_out, 0);
      idle(); step();

      // async reset right after a result
      put(BR_BEQ, 32'h800, 8, 0, 0, 0, 1, 1); step();
      idle(); step();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_val("arst_valid", bus.res_valid, 0);
      check_val("arst_misp", bus.res_mispredict, 0);
      check_val("arst_dest", bus.res_dest, 0);
      check_val("arst_busy", bus.busy_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // random traffic
      for (int c = 0; c < 600; c++) begin
         idle();
         bus.rdy = ($urandom_range(0, 7) != 0);
         bus.flush_in = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 1) == 1)
            put(3'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) < 6) ? 4'd0 : 4'($urandom_range(1, 7)),
                ($urandom_range(0, 9) < 6) ? 4'd0 : 4'($urandom_range(1, 7)),
                pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)]);
         if ($urandom_range(0, 9) < 4) cdb(4'($urandom_range(1, 7)), pool[$urandom_range(0, 3)]);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_branch_rs.md
Name: ex_branch_rs

Overview:
- Parametrised successor to the single-slot branch executor: a DEPTH-entry in-order branch reservation queue with result-bus (CDB) operand wakeup.
- Sits between the allocator (issue side) and IF (redirect side) in the execute stage.
- Resolves BEQ/BNE/BLT/BGE/BLTU/BGEU strictly oldest-first.
- Compares each outcome against the IF prediction and signals a redirect only on mispredict, flushing all younger queued branches.

Parameters:
- DEPTH, 4, queue entries; power of two, ≥2.
- XLEN, 32, data/address width.
- TAG_W, 4, register-tag width; tag value 0 means UNLOCKED (operand present).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rdy  in  1  global enable; 0 freezes the queue.
- flush_in  in  1  external pipeline flush.
- issue_valid  in  1  allocator presents a branch.
- issue_ready  out  1  queue can accept one entry (count<DEPTH).
- issue_op  in  3  branch opcode (BR_* package encoding).
- issue_pc  in  XLEN  branch PC.
- issue_offset  in  XLEN  sign-extended immediate.
- issue_pred_taken  in  1  IF prediction.
- issue_tagx / issue_tagy  in  TAG_W  operand tags.
- issue_datax / issue_datay  in  XLEN  operand values, valid when tag==0.
- cdb_valid  in  1  result-bus broadcast.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  XLEN  broadcast value.
- res_valid  out  1  one-cycle pulse: head branch resolved.
- res_taken  out  1  actual outcome.
- res_mispredict  out  1  outcome differs from prediction; IF must redirect.
- res_dest  out  XLEN  correct next PC.
- busy_out  out  1  count != 0.

Behaviour:
- Reset (async, rst_n=0): head=tail=count=0, all entry valid bits 0, res_* = 0, res_dest=0. Entry payload is not reset.
- Storage: circular buffer. The head and tail pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.
- issue_ready is combinational: (count<DEPTH) && !flush_in. Same-cycle retire does NOT free a slot for issue.
- Issue fire (issue_valid && issue_ready && rdy):
  - Write the entry at tail; tail+1.
  - Same-cycle wakeup: if cdb_valid and the nonzero issue tag equals cdb_tag, store cdb_data and tag 0.
- CDB snoop: every cycle, including rdy=0, each valid entry whose operand tag is nonzero and equals cdb_tag (with cdb_valid) captures cdb_data and clears that tag. The two operands are handled independently; both may match the same broadcast.
- Resolve: the head entry is ready when it is valid and tagx==tagy==0. It resolves on the edge with rdy=1. Younger ready entries never bypass the head.
- Latency: res_* are registered and appear the cycle after the head becomes ready. The head pops on that same edge.
- Outcomes:
  - BEQ =, BNE ≠, BLT/BGE signed, BLTU/BGEU unsigned.
  - Taken target = pc+offset; fall-through = pc+4. Both are mod 2^XLEN and wrap silently.
  - res_dest = the target for the actual outcome.
  - res_mispredict = res_taken ^ pred_taken.
- Illegal opcode: the entry pops with res_valid=0. It is not an error.
- Mispredict: on the resolving edge, clear all entries, set head=tail=0 and count=0. An issue fire in the same cycle is discarded (wrong path).
- flush_in=1:
  - The next edge clears the queue as above.
  - res_valid=0, even if the head was ready.
  - flush_in overrides issue and resolve.
- rdy=0: queue pointers, count and entries hold (CDB snoop excepted). res_valid/res_mispredict are forced 0 on the next edge; res_dest and res_taken hold.
- Simultaneous issue and resolve with a non-full queue: both happen, so count is unchanged.
- Reset asserted mid-operation: immediate clear; no res_valid pulse.

Decomposition:
- Shared package:
  - BR_BEQ..BR_BGEU opcode encodings.
  - UNLOCKED=0 tag constant.
  - XLEN default.
  - Entry record layout: op, pc, offset, pred, tagx, tagy, datax, datay, valid.
- One natural sub-module, br_compare: purely combinational (op, x, y) -> taken/legal, reused by future JALR/fused-compare work.
- Queue control stays in ex_branch_rs.

Test Plan:
- Ready operands: issue BEQ pc=0x100, off=0x20, x=y=5, pred=1 -> next cycle res_valid=1, taken=1, mispredict=0, dest=0x120; busy_out drops.
- Wakeup: issue BLT x=tag3, y=7, pred=0. Two cycles later cdb{tag3, 0xFFFFFFFF} -> res on the following cycle: taken=1 (-1<7 signed), mispredict=1, dest=pc+off.
- Ordering: fill 4 entries; head waits on tag2 while entry1 is ready -> no res until the tag2 broadcast. Then results come out in issue order on consecutive cycles. issue_ready=0 while count=4.
- Flush on mispredict: queue holds 3 entries; head BLTU 1<2 pred=0 resolves while issue_valid=1 -> mispredict=1, count=0, the issued branch is dropped, busy_out=0.
- Wrap and boundary: pc=0xFFFFFFFC BNE taken=0 -> dest=0x00000000. Push/pop 10 branches to wrap the pointers twice -> all results correct and in order.
- Control: rdy=0 for 3 cycles with a ready head -> no res_valid, queue held, CDB still captured. Then flush_in=1 -> queue empty, res_valid stays 0. Async rst_n pulse mid-run -> outputs 0 immediately.
